// File: rtl/exu_bp_update_ctl_if.sv
// Bus bundle between the EXU resolve port, the IFU BHT write port and the statistics port.
// The master modport is the EXU/IFU side. The slave modport is the update controller.
interface exu_bp_update_ctl_if #(
    parameter int IDX_W = 8
);
    logic             res_valid;
    logic [IDX_W-1:0] res_index;
    logic             res_way;
    logic [1:0]       res_hist;
    logic             res_misp;
    logic             res_ataken;
    logic             upd_valid;
    logic             upd_ready;
    logic [IDX_W-1:0] upd_index;
    logic             upd_way;
    logic [1:0]       upd_hist;
    logic             bp_full;
    logic [1:0]       stat_sel;
    logic             stat_clr;
    logic [31:0]      stat_rdata;

    modport master (
        output res_valid, res_index, res_way, res_hist, res_misp, res_ataken,
        output upd_ready, stat_sel, stat_clr,
        input  upd_valid, upd_index, upd_way, upd_hist, bp_full, stat_rdata
    );

    modport slave (
        input  res_valid, res_index, res_way, res_hist, res_misp, res_ataken,
        input  upd_ready, stat_sel, stat_clr,
        output upd_valid, upd_index, upd_way, upd_hist, bp_full, stat_rdata
    );
endinterface

// File: rtl/exu_bp_update_ctl.sv
// BHT update queue: buffers resolved branch history writes toward the IFU.
// It merges back-to-back writes to the same tail entry and keeps resolve/mispredict/taken/drop statistics.
module exu_bp_update_ctl #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 8
) (
    input logic                clk,
    input logic                rst,
    exu_bp_update_ctl_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic [IDX_W-1:0] index;
        logic             way;
        logic [1:0]       hist;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, tail_ptr;
    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0][31:0] stat_q, stat_d;
    logic [3:0]       stat_inc;
    logic             empty, full, pop, tail_hit, coalesce, push, drop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL);
    assign tail_ptr = wr_ptr_q - PTR_W'(1);
    assign pop      = ~empty & bus.upd_ready;
    assign tail_hit = ~empty & (mem_q[tail_ptr].index == bus.res_index)
                             & (mem_q[tail_ptr].way == bus.res_way);
    // A lone entry that is leaving this cycle cannot absorb the new hist.
    assign coalesce = bus.res_valid & tail_hit & ~(pop & (count_q == CNT_W'(1)));
    assign push     = bus.res_valid & ~coalesce & (~full | pop);
    assign drop     = bus.res_valid & ~coalesce & full & ~pop;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (push & ~pop)      count_d = count_q + CNT_W'(1);
        else if (pop & ~push) count_d = count_q - CNT_W'(1);
    end

    assign stat_inc = {drop, bus.res_valid & bus.res_ataken,
                       bus.res_valid & bus.res_misp, bus.res_valid};

    always_comb begin
        stat_d = stat_q;
        for (int i = 0; i < 4; i++)
            stat_d[i] = bus.stat_clr ? 32'd0 : stat_q[i] + 32'(stat_inc[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            stat_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            stat_q   <= stat_d;
        end
    end

    // Payload storage carries no reset; upd_* are only meaningful with upd_valid.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= '{index: bus.res_index, way: bus.res_way, hist: bus.res_hist};
        else if (coalesce)
            mem_q[tail_ptr].hist <= bus.res_hist;
    end

    assign bus.upd_valid  = ~empty;
    assign bus.upd_index  = mem_q[rd_ptr_q].index;
    assign bus.upd_way    = mem_q[rd_ptr_q].way;
    assign bus.upd_hist   = mem_q[rd_ptr_q].hist;
    assign bus.bp_full    = full;
    assign bus.stat_rdata = stat_q[bus.stat_sel];
endmodule

// File: doc/exu_bp_update_ctl.md
EXU_BP_UPDATE_CTL -- requirements
Module: exu_bp_update_ctl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning update-queue entries (power of two, 2..16).
REQ-002 SHALL have parameter IDX_W, default 8, meaning BHT index width.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port res_valid  input  1  resolved conditional branch from EXU this cycle.
REQ-006 SHALL have port res_index  input  IDX_W  BHT index of the resolved branch.
REQ-007 SHALL have port res_way  input  1  BHT way of the resolved branch.
REQ-008 SHALL have port res_hist  input  2  new 2-bit history computed by EXU.
REQ-009 SHALL have port res_misp  input  1  branch mispredicted.
REQ-010 SHALL have port res_ataken  input  1  branch actually taken.
REQ-011 SHALL have port upd_valid  output  1  BHT write request valid.
REQ-012 SHALL have port upd_ready  input  1  IFU accepts the BHT write.
REQ-013 SHALL have port upd_index  output  IDX_W  BHT write index.
REQ-014 SHALL have port upd_way  output  1  BHT write way.
REQ-015 SHALL have port upd_hist  output  2  BHT write data.
REQ-016 SHALL have port bp_full  output  1  queue full.
REQ-017 SHALL have port stat_sel  input  2  statistics select: 0 resolved, 1 mispredicted, 2 taken, 3 dropped.
REQ-018 SHALL have port stat_clr  input  1  synchronous clear of all statistics counters.
REQ-019 SHALL have port stat_rdata  output  32  selected counter value (combinational mux of registered counters).

Function
REQ-020 SHALL hold resolved updates in a DEPTH-entry circular FIFO {index, way, hist} with read pointer, write pointer and occupancy count 0..DEPTH.
REQ-021 SHALL drive upd_valid = (count != 0) and upd_index/upd_way/upd_hist from the head entry; no bypass, so the minimum latency from res_valid to upd_valid is 1 cycle.
REQ-022 SHALL pop the head when upd_valid & upd_ready; upd_* SHALL stay stable while upd_valid & ~upd_ready.
REQ-023 SHALL coalesce: if res_valid, count != 0, {res_index,res_way} equals the tail entry, and the tail is not being popped this cycle, it SHALL overwrite the tail hist and SHALL NOT allocate.
REQ-024 SHALL otherwise enqueue on res_valid when count < DEPTH, or when count == DEPTH and a pop occurs the same cycle.
REQ-025 SHALL drop a non-coalesced res_valid when count == DEPTH and no pop occurs that cycle; the queue state is unchanged.
REQ-026 SHALL wrap both pointers modulo DEPTH; simultaneous push and pop SHALL leave count unchanged.
REQ-027 SHALL drive bp_full = (count == DEPTH).
REQ-028 SHALL keep four 32-bit counters: resolved (+1 per res_valid), mispredicted (+1 per res_valid & res_misp), taken (+1 per res_valid & res_ataken), and dropped (+1 per drop per REQ-025).
REQ-029 SHALL count coalesced and dropped packets in the resolved, mispredicted and taken counters.
REQ-030 SHALL wrap each counter from 0xFFFF_FFFF to 0.
REQ-031 SHALL give stat_clr priority: when stat_clr coincides with an increment, the counter SHALL become 0.

Reset
REQ-032 SHALL, while rst is high, immediately force count, pointers and all counters to 0 and force upd_valid=0, bp_full=0, stat_rdata=0.
REQ-033 SHALL NOT reset FIFO data storage, and upd_index/upd_way/upd_hist are don't-care while upd_valid=0.
REQ-034 SHALL discard all queued updates and any in-progress handshake when rst is asserted mid-operation; after release, the first res_valid SHALL be treated as entering an empty queue.

Verification
REQ-035 SHALL cover single update: one res_valid with index 0x12, way 1, hist 2'b10, upd_ready=1 -> upd_valid=1 the next cycle only, with 0x12/1/10; resolved counter=1.
REQ-036 SHALL cover fill and drop: upd_ready=0 and 5 distinct indices with DEPTH=4 -> bp_full=1 after 4; 5th dropped; dropped counter=1; resolved counter=5; drain order is indices 1..4.
REQ-037 SHALL cover full with simultaneous pop: count=4, upd_ready=1 and new res_valid -> accepted, count stays 4, dropped counter unchanged.
REQ-038 SHALL cover coalescing: index 0x05 hist 01, then index 0x05 hist 11 next cycle with upd_ready=0 -> count=1, head hist=11; with the tail being popped, the second packet instead allocates and count=1 after the cycle.
REQ-039 SHALL cover statistics: 3 res_valid with misp=1 and ataken=1 -> stat_sel=1 and stat_sel=2 each read 3; stat_clr together with res_valid -> all read 0 the next cycle.
REQ-040 SHALL cover reset mid-operation: rst asserted with count=3 -> upd_valid=0 without waiting for a clock edge, all counters 0; after release, one res_valid -> upd_valid the next cycle.
